boot_loader_ctrl: RTL and testbench

UART boot-load controller that writes a program image into data/instruction RAM over the serial link, then restarts the single-cycle CPU. It sits between the CPU data port and the shared data memory write port. During a load it owns the memory write port and holds the CPU in reset. Otherwise it passes CPU data traffic straight through.

---
 rtl/boot_pkg.sv | 23 ++
 rtl/boot_loader_ctrl_if.sv | 33 +++
 rtl/boot_word_asm.sv | 43 ++++
 rtl/boot_loader_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_boot_loader_ctrl.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/boot_pkg.sv
// rtl/boot_pkg.sv - shared state encoding and protocol bytes for the UART boot loader
package boot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN_LO  = 3'd1,
        ST_LEN_HI  = 3'd2,
        ST_DATA    = 3'd3,
        ST_SUM     = 3'd4,
        ST_RESP    = 3'd5,
        ST_RELEASE = 3'd6
    } boot_state_t;

    localparam logic [7:0] BOOT_MAGIC = 8'hA5;
    localparam logic [7:0] BOOT_ACK   = 8'h06;
    localparam logic [7:0] BOOT_NAK   = 8'h15;

    // Byte address of word n of the image, relative to the load base.
    function automatic logic [31:0] word_offset(input logic [15:0] idx);
        return {14'd0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/boot_loader_ctrl_if.sv
// rtl/boot_loader_ctrl_if.sv - UART byte stream, CPU data port and memory write port bundle
//
// master: the boot loader (drives tx_*, mem_*, cpu_resetn and status)
// slave : the surrounding system (drives rx_*, tx_ready and the CPU store port)
interface boot_loader_ctrl_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        tx_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        cpu_wmem;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_resetn;
    logic        busy;
    logic        load_done;
    logic        load_err;

    modport master (
        input  rx_valid, rx_data, tx_ready, cpu_wmem, cpu_addr, cpu_wdata,
        output tx_valid, tx_data, mem_we, mem_addr, mem_wdata,
               cpu_resetn, busy, load_done, load_err
    );

    modport slave (
        output rx_valid, rx_data, tx_ready, cpu_wmem, cpu_addr, cpu_wdata,
        input  tx_valid, tx_data, mem_we, mem_addr, mem_wdata,
               cpu_resetn, busy, load_done, load_err
    );
endinterface

// File: rtl/boot_word_asm.sv
// rtl/boot_word_asm.sv - little-endian byte-to-word assembler with 8-bit additive checksum
//
// Ports: clk, resetn (async active-low); clr restarts byte count and checksum;
// en/data accept one byte; word is the shift register; last flags that the
// byte now being accepted completes a word; word_ready pulses the cycle after;
// sum is the running mod-256 byte sum.
module boot_word_asm (
    input  logic        clk,
    input  logic        resetn,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] word,
    output logic        last,
    output logic        word_ready,
    output logic [7:0]  sum
);

    logic [1:0] byte_idx;

    assign last = (byte_idx == 2'd3);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            word       <= 32'd0;
            byte_idx   <= 2'd0;
            sum        <= 8'd0;
            word_ready <= 1'b0;
        end else begin
            word_ready <= en && last && !clr;
            if (clr) begin
                byte_idx <= 2'd0;
                sum      <= 8'd0;
            end else if (en) begin
                // First byte ends up in bits [7:0] after four shifts.
                word     <= {data, word[31:8]};
                byte_idx <= byte_idx + 2'd1;
                sum      <= sum + data;
            end
        end
    end

endmodule

// File: rtl/boot_loader_ctrl.sv
// rtl/boot_loader_ctrl.sv - UART boot-load FSM, memory write-port mux and CPU reset control
//
// Ports: clk, resetn (async active-low), bus (boot_loader_ctrl_if.master).
// Optional macro BOOT_TIMEOUT_EN: aborts a load with NAK after TIMEOUT_CYCLES
// without a received byte; without it a stalled transfer waits forever.
module boot_loader_ctrl
    import boot_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0800,
    parameter int          MAX_WORDS      = 1024,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd5_000_000
) (
    input  logic               clk,
    input  logic               resetn,
    boot_loader_ctrl_if.master bus
);

    boot_state_t state, state_nx;
    logic        busy, busy_nx;
    logic        load_done, load_done_nx;
    logic        load_err, load_err_nx;
    logic        cpu_rst_n, cpu_rst_n_nx;
    logic        tx_valid, tx_valid_nx;
    logic [7:0]  tx_data, tx_data_nx;
    logic [15:0] len, len_nx;
    logic [15:0] word_idx, word_idx_nx;
    logic [31:0] wr_addr, wr_addr_nx;
    logic        asm_clr, asm_en;
    logic [31:0] asm_word;
    logic        asm_last, asm_ready;
    logic [7:0]  asm_sum;
    logic [15:0] len_rx;
    logic        loading;
    logic        timeout_hit;

    boot_word_asm u_asm (
        .clk        (clk),
        .resetn     (resetn),
        .clr        (asm_clr),
        .en         (asm_en),
        .data       (bus.rx_data),
        .word       (asm_word),
        .last       (asm_last),
        .word_ready (asm_ready),
        .sum        (asm_sum)
    );

    assign len_rx  = {bus.rx_data, len[7:0]};
    assign loading = (state == ST_LEN_LO) || (state == ST_LEN_HI) ||
                     (state == ST_DATA)   || (state == ST_SUM);

`ifdef BOOT_TIMEOUT_EN
    logic [23:0] gap_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            gap_cnt <= 24'd0;
        end else if (bus.rx_valid || !loading) begin
            gap_cnt <= 24'd0;
        end else if (gap_cnt != TIMEOUT_CYCLES) begin
            gap_cnt <= gap_cnt + 24'd1;
        end
    end

    assign timeout_hit = loading && !bus.rx_valid && (gap_cnt == TIMEOUT_CYCLES);
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            cpu_rst_n <= 1'b0;
            tx_valid  <= 1'b0;
            tx_data   <= 8'd0;
            len       <= 16'd0;
            word_idx  <= 16'd0;
            wr_addr   <= 32'd0;
        end else begin
            state     <= state_nx;
            busy      <= busy_nx;
            load_done <= load_done_nx;
            load_err  <= load_err_nx;
            cpu_rst_n <= cpu_rst_n_nx;
            tx_valid  <= tx_valid_nx;
            tx_data   <= tx_data_nx;
            len       <= len_nx;
            word_idx  <= word_idx_nx;
            wr_addr   <= wr_addr_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        busy_nx      = busy;
        load_done_nx = load_done;
        load_err_nx  = load_err;
        cpu_rst_n_nx = cpu_rst_n;
        tx_valid_nx  = tx_valid;
        tx_data_nx   = tx_data;
        len_nx       = len;
        word_idx_nx  = word_idx;
        wr_addr_nx   = wr_addr;
        asm_clr      = 1'b0;
        asm_en       = 1'b0;

        case (state)
            ST_IDLE: begin
                // Also releases the CPU on the first edge after reset.
                cpu_rst_n_nx = 1'b1;
                if (bus.rx_valid && bus.rx_data == BOOT_MAGIC) begin
                    state_nx     = ST_LEN_LO;
                    cpu_rst_n_nx = 1'b0;
                    busy_nx      = 1'b1;
                    load_done_nx = 1'b0;
                    load_err_nx  = 1'b0;
                    word_idx_nx  = 16'd0;
                    asm_clr      = 1'b1;
                end
            end
            ST_LEN_LO: begin
                if (bus.rx_valid) begin
                    len_nx   = {8'd0, bus.rx_data};
                    state_nx = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (bus.rx_valid) begin
                    len_nx = len_rx;
                    if (len_rx == 16'd0 || 32'(len_rx) > 32'(MAX_WORDS)) begin
                        state_nx    = ST_RESP;
                        tx_valid_nx = 1'b1;
                        tx_data_nx  = BOOT_NAK;
                    end else begin
                        state_nx    = ST_DATA;
                        word_idx_nx = 16'd0;
                        asm_clr     = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                asm_en = bus.rx_valid;
                // Address is latched with the completing byte so the write,
                // one cycle later, is unaffected by the index increment.
                if (bus.rx_valid && asm_last) begin
                    wr_addr_nx  = BASE_ADDR + word_offset(word_idx);
                    word_idx_nx = word_idx + 16'd1;
                    if (word_idx + 16'd1 == len) begin
                        state_nx = ST_SUM;
                    end
                end
            end
            ST_SUM: begin
                if (bus.rx_valid) begin
                    state_nx    = ST_RESP;
                    tx_valid_nx = 1'b1;
                    tx_data_nx  = (bus.rx_data == asm_sum) ? BOOT_ACK : BOOT_NAK;
                end
            end
            ST_RESP: begin
                if (bus.tx_ready) begin
                    state_nx     = ST_RELEASE;
                    tx_valid_nx  = 1'b0;
                    busy_nx      = 1'b0;
                    cpu_rst_n_nx = 1'b1;
                    load_done_nx = (tx_data == BOOT_ACK);
                    load_err_nx  = (tx_data != BOOT_ACK);
                end
            end
            ST_RELEASE: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase

        if (timeout_hit) begin
            state_nx    = ST_RESP;
            tx_valid_nx = 1'b1;
            tx_data_nx  = BOOT_NAK;
            asm_en      = 1'b0;
        end
    end

    // Only IDLE hands the write port to the CPU; every loader state
    // (including RELEASE) shields memory from CPU stores.
    always_comb begin
        if (state == ST_IDLE) begin
            bus.mem_we    = bus.cpu_wmem;
            bus.mem_addr  = bus.cpu_addr;
            bus.mem_wdata = bus.cpu_wdata;
        end else begin
            bus.mem_we    = asm_ready;
            bus.mem_addr  = wr_addr;
            bus.mem_wdata = asm_word;
        end
    end

    assign bus.tx_valid   = tx_valid;
    assign bus.tx_data    = tx_data;
    assign bus.cpu_resetn = cpu_rst_n;
    assign bus.busy       = busy;
    assign bus.load_done  = load_done;
    assign bus.load_err   = load_err;

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// tb/tb_boot_loader_ctrl.sv - directed self-checking bench for boot_loader_ctrl
module tb_boot_loader_ctrl;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [31:0] wr_a[$];
    logic [31:0] wr_d[$];

    boot_loader_ctrl_if bus ();

`ifdef BOOT_TIMEOUT_EN
    boot_loader_ctrl #(.TIMEOUT_CYCLES(24'd100)) dut (
`else
    boot_loader_ctrl dut (
`endif
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.master)
    );

    always #5 clk = ~clk;

    // Loader writes happen only while busy; record each one-cycle pulse.
    always @(negedge clk) begin
        if (resetn && bus.busy && bus.mem_we) begin
            wr_a.push_back(bus.mem_addr);
            wr_d.push_back(bus.mem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_bytes(input logic [7:0] bytes[$]);
        foreach (bytes[i]) send_byte(bytes[i]);
    endtask

    task automatic wait_tx(input string tag, input int budget);
        int k;
        k = 0;
        while (!bus.tx_valid && k < budget) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_tx_valid"}, 32'(bus.tx_valid), 32'd1);
    endtask

    task automatic handshake(input string tag, input logic done_exp);
        @(negedge clk);
        bus.tx_ready = 1'b1;
        @(negedge clk);
        bus.tx_ready = 1'b0;
        check({tag, "_tx_drop"}, 32'(bus.tx_valid), 32'd0);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_cpu_rst"}, 32'(bus.cpu_resetn), 32'd1);
        check({tag, "_done"}, 32'(bus.load_done), 32'(done_exp));
        check({tag, "_err"}, 32'(bus.load_err), 32'(!done_exp));
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int bad;
        bus.rx_valid  = 1'b0;
        bus.rx_data   = 8'd0;
        bus.tx_ready  = 1'b0;
        bus.cpu_wmem  = 1'b0;
        bus.cpu_addr  = 32'd0;
        bus.cpu_wdata = 32'd0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_cpu_resetn", 32'(bus.cpu_resetn), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
        check("rst_tx_data", 32'(bus.tx_data), 32'd0);
        check("rst_done", 32'(bus.load_done), 32'd0);
        check("rst_err", 32'(bus.load_err), 32'd0);
        resetn = 1'b1;
        @(negedge clk);
        check("cpu_release", 32'(bus.cpu_resetn), 32'd1);

        // Pass-through
        bus.cpu_wmem  = 1'b1;
        bus.cpu_addr  = 32'h10;
        bus.cpu_wdata = 32'hDEADBEEF;
        #1;
        check("pt_we", 32'(bus.mem_we), 32'd1);
        check("pt_addr", bus.mem_addr, 32'h10);
        check("pt_wdata", bus.mem_wdata, 32'hDEADBEEF);
        @(negedge clk);
        bus.cpu_wmem = 1'b0;

        // Non-magic bytes are ignored
        send_byte(8'h5A);
        check("ign_busy", 32'(bus.busy), 32'd0);

        // Good load: byte sum 78+56+34+12+EF+BE+AD+DE = 0x44C -> 8'h4C
        wr_a.delete(); wr_d.delete();
        send_byte(8'hA5);
        check("good_magic_cpu_rst", 32'(bus.cpu_resetn), 32'd0);
        check("good_magic_busy", 32'(bus.busy), 32'd1);
        bus.cpu_wmem = 1'b1;   // CPU stores must not reach memory during a load
        bus.cpu_addr = 32'h44;
        send_bytes('{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                     8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h4C});
        bus.cpu_wmem = 1'b0;
        wait_tx("good", 50);
        check("good_tx_data", 32'(bus.tx_data), 32'h06);
        check("good_cpu_held", 32'(bus.cpu_resetn), 32'd0);
        check("good_nwr", wr_a.size(), 32'd2);
        if (wr_a.size() == 2) begin
            check("good_a0", wr_a[0], 32'h800);
            check("good_d0", wr_d[0], 32'h12345678);
            check("good_a1", wr_a[1], 32'h804);
            check("good_d1", wr_d[1], 32'hDEADBEEF);
        end
        handshake("good", 1'b1);

        // Bad checksum
        wr_a.delete(); wr_d.delete();
        send_bytes('{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                     8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h00});
        wait_tx("badsum", 50);
        check("badsum_tx_data", 32'(bus.tx_data), 32'h15);
        check("badsum_nwr", wr_a.size(), 32'd2);
        handshake("badsum", 1'b0);

        // Length guard N=0
        wr_a.delete(); wr_d.delete();
        send_bytes('{8'hA5, 8'h00, 8'h00});
        wait_tx("len0", 50);
        check("len0_tx_data", 32'(bus.tx_data), 32'h15);
        check("len0_nwr", wr_a.size(), 32'd0);
        handshake("len0", 1'b0);

        // Length guard N=1025
        send_bytes('{8'hA5, 8'h01, 8'h04});
        wait_tx("len1025", 50);
        check("len1025_tx_data", 32'(bus.tx_data), 32'h15);
        check("len1025_nwr", wr_a.size(), 32'd0);
        handshake("len1025", 1'b0);

        // Magic byte as data, then backpressure: sum A5+11+22+33 = 0x10B -> 8'h0B
        wr_a.delete(); wr_d.delete();
        send_bytes('{8'hA5, 8'h01, 8'h00, 8'hA5, 8'h11, 8'h22, 8'h33, 8'h0B});
        wait_tx("bp", 50);
        bad = 0;
        for (int c = 0; c < 50; c++) begin
            if (!bus.tx_valid || bus.tx_data !== 8'h06 || bus.cpu_resetn !== 1'b0) bad++;
            if (c == 10) send_byte(8'hA5);   // dropped while responding
            @(negedge clk);
        end
        check("bp_stable_bad_cycles", bad, 32'd0);
        check("bp_nwr", wr_a.size(), 32'd1);
        if (wr_a.size() == 1) begin
            check("bp_a0", wr_a[0], 32'h800);
            check("bp_d0", wr_d[0], 32'h3322_11A5);
        end
        handshake("bp", 1'b1);
        check("bp_idle_after", 32'(bus.busy), 32'd0);

`ifdef BOOT_TIMEOUT_EN
        // Stalled transfer aborts
        send_bytes('{8'hA5, 8'h01, 8'h00, 8'h78});
        wait_tx("tmo", 300);
        check("tmo_tx_data", 32'(bus.tx_data), 32'h15);
        handshake("tmo", 1'b0);
`endif

        // Reset mid-DATA
        send_bytes('{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56});
        check("abort_pre_busy", 32'(bus.busy), 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_cpu_rst", 32'(bus.cpu_resetn), 32'd0);
        check("abort_tx_valid", 32'(bus.tx_valid), 32'd0);
        check("abort_done", 32'(bus.load_done), 32'd0);
        check("abort_mem_we", 32'(bus.mem_we), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("abort_cpu_release", 32'(bus.cpu_resetn), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
